// File: rtl/add_int_pipe_128.sv
// -----------------------------------------------------------------------------
// add_int_pipe_128
// Two-stage, valid/ready flow-controlled integer adder built around a 128-bit
// hierarchical carry-lookahead core (4-bit groups, three lookahead levels).
//   S1: operand register (A, B already inverted for subtract, carry-in)
//   S2: result register (sum, carry-out, zero, optional signed overflow)
// A beat is accepted on in_valid & in_ready. Its result appears on out_valid
// two cycles later. Under continuous flow the block sustains one beat per cycle.
//
// Ports
//   clk        in   1       clock, rising edge
//   rst        in   1       asynchronous reset, active high
//   in_valid   in   1       operand beat valid
//   in_ready   out  1       operand beat can be accepted (combinational)
//   in_a       in   DATA_W  operand A
//   in_b       in   DATA_W  operand B
//   in_sub     in   1       1: A-B, 0: A+B+in_cin
//   in_cin     in   1       carry-in, ignored for subtract
//   out_valid  out  1       result beat valid
//   out_ready  in   1       consumer accepts the result
//   out_sum    out  DATA_W  sum / difference mod 2^DATA_W
//   out_cout   out  1       carry out of the MSB (subtract: 1 = no borrow)
//   out_zero   out  1       out_sum == 0
//   out_ovf    out  1       signed overflow
//
// Configuration
//   ADD_INT_PIPE_OVF_EN  defined: out_ovf is computed and registered in S2.
//                        undefined: out_ovf is tied low, no register is built.
//
// Only DATA_W = 128 is supported; the lookahead tree is sized for it.
// -----------------------------------------------------------------------------
module add_int_pipe_128 #(
    parameter int unsigned       DATA_W  = 128,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_sub,
    input  logic              in_cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_cout,
    output logic              out_zero,
    output logic              out_ovf
);

    // Lookahead tree geometry: 128 bits -> 32 groups -> 8 groups -> 2 groups.
    localparam int unsigned CLA_W = 128;
    localparam int unsigned L1_N  = CLA_W / 4;
    localparam int unsigned L2_N  = L1_N / 4;
    localparam int unsigned L3_N  = L2_N / 4;
    localparam int unsigned MSB   = DATA_W - 1;

    // -------------------------------------------------------------------------
    // 4-bit lookahead primitives
    // -------------------------------------------------------------------------

    // Group generate; p_hi carries propagate bits [3:1] (bit 0 does not matter).
    function automatic logic grp_g(input logic [3:0] g, input logic [2:0] p_hi);
        return g[3]
             | (p_hi[2] & g[2])
             | (p_hi[2] & p_hi[1] & g[1])
             | (p_hi[2] & p_hi[1] & p_hi[0] & g[0]);
    endfunction

    // Carries into each of the four members of a group, given the group carry-in.
    function automatic logic [3:0] grp_c(input logic [2:0] g, input logic [2:0] p,
                                         input logic ci);
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake / stage control
    // -------------------------------------------------------------------------
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic adv1, adv2, in_fire;

    // S2 can take a beat when empty or draining; S1 moves only into a free S2.
    assign adv2     = ~v2_q | out_ready;
    assign adv1     = v1_q & adv2;
    assign in_ready = ~v1_q | adv2;
    assign in_fire  = in_valid & in_ready;

    // -------------------------------------------------------------------------
    // S1: operand register
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] a1_q, a1_d;
    logic [DATA_W-1:0] b1_q, b1_d;
    logic              c1_q, c1_d;

    // Subtract is folded in at capture: A + ~B + 1.
    always_comb begin : s1_next
        v1_d = v1_q;
        a1_d = a1_q;
        b1_d = b1_q;
        c1_d = c1_q;
        if (in_fire) begin
            v1_d = 1'b1;
            a1_d = in_a;
            b1_d = in_sub ? ~in_b : in_b;
            c1_d = in_sub | in_cin;
        end else if (adv1) begin
            v1_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Carry-lookahead core, driven straight from S1
    // -------------------------------------------------------------------------
    logic [CLA_W-1:0] p0, g0, c0;
    logic [L1_N-1:0]  p1, g1, c1;
    logic [L2_N-1:0]  p2, g2, c2;
    logic [L3_N-1:0]  p3, g3, c3;
    logic             pm, gm;
    logic [CLA_W-1:0] cla_sum;
    logic             cla_cout;

    // Bit-level propagate / generate.
    always_comb begin : bit_pg
        p0 = a1_q ^ b1_q;
        g0 = a1_q & b1_q;
    end

    // Level 1: 4-bit groups.
    always_comb begin : lvl1_pg
        p1 = '0;
        g1 = '0;
        for (int unsigned j = 0; j < L1_N; j++) begin
            g1[j] = grp_g(g0[4*j +: 4], p0[4*j+1 +: 3]);
            p1[j] = &p0[4*j +: 4];
        end
    end

    // Level 2: 16-bit groups.
    always_comb begin : lvl2_pg
        p2 = '0;
        g2 = '0;
        for (int unsigned j = 0; j < L2_N; j++) begin
            g2[j] = grp_g(g1[4*j +: 4], p1[4*j+1 +: 3]);
            p2[j] = &p1[4*j +: 4];
        end
    end

    // Level 3: 64-bit groups.
    always_comb begin : lvl3_pg
        p3 = '0;
        g3 = '0;
        for (int unsigned j = 0; j < L3_N; j++) begin
            g3[j] = grp_g(g2[4*j +: 4], p2[4*j+1 +: 3]);
            p3[j] = &p2[4*j +: 4];
        end
    end

    // Whole-word propagate / generate and the carries into the two 64-bit halves.
    always_comb begin : top_carry
        gm    = g3[1] | (p3[1] & g3[0]);
        pm    = p3[1] & p3[0];
        c3[0] = c1_q;
        c3[1] = g3[0] | (p3[0] & c1_q);
    end

    // Carries distributed back down the tree.
    always_comb begin : lvl2_carry
        c2 = '0;
        for (int unsigned k = 0; k < L3_N; k++) begin
            c2[4*k +: 4] = grp_c(g2[4*k +: 3], p2[4*k +: 3], c3[k]);
        end
    end

    always_comb begin : lvl1_carry
        c1 = '0;
        for (int unsigned k = 0; k < L2_N; k++) begin
            c1[4*k +: 4] = grp_c(g1[4*k +: 3], p1[4*k +: 3], c2[k]);
        end
    end

    always_comb begin : bit_carry
        c0 = '0;
        for (int unsigned k = 0; k < L1_N; k++) begin
            c0[4*k +: 4] = grp_c(g0[4*k +: 3], p0[4*k +: 3], c1[k]);
        end
    end

    // Sum bits and carry-out of the MSB.
    always_comb begin : cla_out
        cla_sum  = p0 ^ c0;
        cla_cout = gm | (pm & c1_q);
    end

    // -------------------------------------------------------------------------
    // S2: result register
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              zero_q, zero_d;

    // Data only moves on adv1; a drain without a new beat just clears valid.
    always_comb begin : s2_next
        v2_d   = v2_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        zero_d = zero_q;
        if (adv1) begin
            v2_d   = 1'b1;
            sum_d  = cla_sum;
            cout_d = cla_cout;
            zero_d = ~|cla_sum;
        end else if (out_ready) begin
            v2_d = 1'b0;
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= RST_VAL;
            b1_q   <= RST_VAL;
            c1_q   <= 1'b0;
            v2_q   <= 1'b0;
            sum_q  <= RST_VAL;
            cout_q <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            c1_q   <= c1_d;
            v2_q   <= v2_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            zero_q <= zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Optional signed overflow flag
    // -------------------------------------------------------------------------
`ifdef ADD_INT_PIPE_OVF_EN
    logic ovf_q, ovf_d;

    // Overflow: operands share a sign and the result sign differs from it.
    always_comb begin : ovf_next
        ovf_d = ovf_q;
        if (adv1) begin
            ovf_d = (a1_q[MSB] ~^ b1_q[MSB]) & (cla_sum[MSB] ^ a1_q[MSB]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

    // Registered outputs.
    assign out_valid = v2_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_add_int_pipe_128.sv
// -----------------------------------------------------------------------------
// tb_add_int_pipe_128
// Directed and streaming checks for add_int_pipe_128. Inputs change 1 ns after
// the rising edge; outputs are sampled 1 ns after the edge or mid-cycle.
// A monitor predicts every accepted beat with a 129-bit arithmetic model and
// compares results in order as they leave the block.
// -----------------------------------------------------------------------------
module tb_add_int_pipe_128;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_a;
    logic [127:0] in_b;
    logic         in_sub;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_sum;
    logic         out_cout;
    logic         out_zero;
    logic         out_ovf;

    add_int_pipe_128 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;

    typedef struct packed {
        logic         cout;
        logic         zero;
        logic         ovf;
        logic [127:0] sum;
    } res_t;

    res_t exp_q[$];

    task automatic check_eq(input string tag, input logic [130:0] got, input logic [130:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain wide addition, subtract as A + ~B + 1.
    function automatic res_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic sub, input logic cin);
        res_t         r;
        logic [127:0] bb;
        logic [128:0] s;
        bb     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bb} + 129'(sub | cin);
        r.sum  = s[127:0];
        r.cout = s[128];
        r.zero = (s[127:0] == 128'd0);
`ifdef ADD_INT_PIPE_OVF_EN
        r.ovf  = (a[127] == bb[127]) && (s[127] != a[127]);
`else
        r.ovf  = 1'b0;
`endif
        return r;
    endfunction

    // Scoreboard: push on accept, pop and compare on result handshake.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_out_valid", 131'(out_valid), 131'(0));
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    check_eq("stream_result", {out_cout, out_zero, out_ovf, out_sum},
                             {e.cout, e.zero, e.ovf, e.sum});
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_sub, in_cin));
            end
        end
    end

    // One beat through an idle pipeline; checks the 2-cycle latency.
    task automatic do_beat(input string tag, input logic [127:0] a, input logic [127:0] b,
                           input logic sub, input logic cin,
                           output logic [127:0] sum, output logic cout,
                           output logic zero, output logic ovf);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_cin    = cin;
        out_ready = 1'b1;
        #4;
        check_eq({tag, "_in_ready"}, 131'(in_ready), 131'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq({tag, "_lat1_valid"}, 131'(out_valid), 131'(0));
        @(posedge clk); #1;
        check_eq({tag, "_lat2_valid"}, 131'(out_valid), 131'(1));
        sum  = out_sum;
        cout = out_cout;
        zero = out_zero;
        ovf  = out_ovf;
    endtask

    logic [127:0] r_sum;
    logic         r_cout, r_zero, r_ovf;
    logic         exp_ovf;
    logic         acc;
    int           idx, base, stalls, vcount;
    logic [127:0] bp_a [4];
    logic [127:0] bp_b [4];

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        in_cin    = 1'b0;
        out_ready = 1'b0;

        // Reset state.
        #2;
        check_eq("rst_out_valid", 131'(out_valid), 131'(0));
        check_eq("rst_out_sum",   131'(out_sum),   131'(0));
        check_eq("rst_out_cout",  131'(out_cout),  131'(0));
        check_eq("rst_out_zero",  131'(out_zero),  131'(0));
        check_eq("rst_out_ovf",   131'(out_ovf),   131'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 131'(in_ready), 131'(1));
        @(posedge clk); #1;

        // Add wrap-around: all-ones + 1.
        do_beat("add_wrap", {128{1'b1}}, 128'd1, 1'b0, 1'b0, r_sum, r_cout, r_zero, r_ovf);
        check_eq("add_wrap_sum",  131'(r_sum),  131'(0));
        check_eq("add_wrap_cout", 131'(r_cout), 131'(1));
        check_eq("add_wrap_zero", 131'(r_zero), 131'(1));
        check_eq("add_wrap_ovf",  131'(r_ovf),  131'(0));

        // Subtract with borrow: 5 - 7.
        do_beat("sub_neg", 128'd5, 128'd7, 1'b1, 1'b0, r_sum, r_cout, r_zero, r_ovf);
        check_eq("sub_neg_sum",  131'(r_sum),  131'(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE));
        check_eq("sub_neg_cout", 131'(r_cout), 131'(0));
        check_eq("sub_neg_zero", 131'(r_zero), 131'(0));

        // Signed overflow: max positive + 1.
`ifdef ADD_INT_PIPE_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        do_beat("ovf", 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                r_sum, r_cout, r_zero, r_ovf);
        check_eq("ovf_sum",  131'(r_sum),  131'(128'h8000_0000_0000_0000_0000_0000_0000_0000));
        check_eq("ovf_cout", 131'(r_cout), 131'(0));
        check_eq("ovf_flag", 131'(r_ovf),  131'(exp_ovf));

        // Carry-in only, and subtract of equal operands (in_cin ignored).
        do_beat("cin_only", 128'd0, 128'd0, 1'b0, 1'b1, r_sum, r_cout, r_zero, r_ovf);
        check_eq("cin_only_sum", 131'(r_sum), 131'(1));
        do_beat("sub_eq", 128'h1234_5678, 128'h1234_5678, 1'b1, 1'b0, r_sum, r_cout, r_zero, r_ovf);
        check_eq("sub_eq_sum",  131'(r_sum),  131'(0));
        check_eq("sub_eq_cout", 131'(r_cout), 131'(1));
        check_eq("sub_eq_zero", 131'(r_zero), 131'(1));

        // Carry rippling across a 64-bit boundary.
        do_beat("carry64", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                r_sum, r_cout, r_zero, r_ovf);
        check_eq("carry64_sum", 131'(r_sum), 131'(128'h0000_0000_0000_0001_0000_0000_0000_0000));

        // Mid-stream reset.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            in_a      = 128'd100 + 128'(i);
            in_b      = 128'd3;
            in_sub    = 1'b0;
            in_cin    = 1'b0;
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_out_valid", 131'(out_valid), 131'(0));
        check_eq("midrst_out_sum",   131'(out_sum),   131'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("midrst_in_ready", 131'(in_ready), 131'(1));
        @(posedge clk); #1;
        do_beat("post_rst", 128'd40, 128'd2, 1'b0, 1'b0, r_sum, r_cout, r_zero, r_ovf);
        check_eq("post_rst_sum", 131'(r_sum), 131'(42));

        // Backpressure: 4 back-to-back beats, consumer stalled for 3 cycles.
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            bp_a[k] = 128'd1000 * 128'(k + 1);
            bp_b[k] = 128'(k);
        end
        idx  = 0;
        base = n_out;
        for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = 1'b1;
            in_a      = bp_a[idx];
            in_b      = bp_b[idx];
            in_sub    = 1'b0;
            in_cin    = 1'b0;
            #4;
            if (cyc == 2) begin
                check_eq("bp_accepts_before_full", 131'(idx), 131'(2));
                check_eq("bp_full_in_ready",       131'(in_ready), 131'(0));
                check_eq("bp_full_out_valid",      131'(out_valid), 131'(1));
            end
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_accepted", 131'(idx), 131'(4));
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_results", 131'(n_out - base), 131'(4));
        check_eq("bp_drained", 131'(exp_q.size()), 131'(0));

        // Streaming: 100 random beats, both sides always ready.
        base   = n_out;
        stalls = 0;
        vcount = 0;
        for (int cyc = 0; cyc < 102; cyc++) begin
            out_ready = 1'b1;
            in_valid  = (cyc < 100);
            if (cyc < 100) begin
                in_a   = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_b   = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_sub = 1'($urandom_range(0, 1));
                in_cin = 1'($urandom_range(0, 1));
            end
            #4;
            if (cyc < 100 && !in_ready) stalls++;
            if (out_valid) vcount++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check_eq("stream_stalls",        131'(stalls), 131'(0));
        check_eq("stream_valid_cycles",  131'(vcount), 131'(100));
        check_eq("stream_results",       131'(n_out - base), 131'(100));
        check_eq("stream_drained",       131'(exp_q.size()), 131'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
